// File: rtl/ks_multiword_sequencer_if.sv
// rtl/ks_multiword_sequencer_if.sv - start/result handshake bundle for the word-serial add/sub sequencer
interface ks_multiword_sequencer_if #(
  parameter int SIZE  = 8,
  parameter int WORDS = 4
);
  localparam int W = WORDS * SIZE;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         c_in;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         c_out;
  logic         overflow;
  logic         busy;

  modport master (
    output start_valid, op_a, op_b, sub, c_in, res_ready,
    input  start_ready, res_valid, result, c_out, overflow, busy
  );

  modport slave (
    input  start_valid, op_a, op_b, sub, c_in, res_ready,
    output start_ready, res_valid, result, c_out, overflow, busy
  );
endinterface

// File: rtl/ks_multiword_sequencer.sv
// rtl/ks_multiword_sequencer.sv - word-serial multi-precision add/sub on a shared Kogge-Stone adder
// Operands shift right one word per RUN cycle; sums shift in from the top so result ends LSW-aligned.
module ks_adder #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            c_in,
  output logic [SIZE-1:0] sum,
  output logic            c_out
);
  // Carry-in is folded into bit 0's generate, so every prefix G[i] is the carry into bit i+1.
  function automatic logic [SIZE:0] ks_add(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                                           input logic ci);
    logic [SIZE-1:0] hp, g, p, gn, pn;
    hp   = x ^ y;
    g    = x & y;
    g[0] = g[0] | (hp[0] & ci);
    p    = hp;
    for (int d = 1; d < SIZE; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < SIZE; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    return {g[SIZE-1], hp ^ {g[SIZE-2:0], ci}};
  endfunction

  assign {c_out, sum} = ks_add(a, b, c_in);
endmodule

module ks_multiword_sequencer #(
  parameter int SIZE  = 8,
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  ks_multiword_sequencer_if.slave    bus
);
  localparam int            W        = WORDS * SIZE;
  localparam int            IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            c_out_q, c_out_d;
  logic            ovf_q, ovf_d;

  logic [SIZE-1:0] slice_sum;
  logic            slice_c;

  ks_adder #(.SIZE(SIZE)) u_adder (
    .a     (a_q[SIZE-1:0]),
    .b     (b_q[SIZE-1:0]),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_c)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_valid) begin
          a_d      = bus.op_a;
          b_d      = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d  = bus.sub ? 1'b1 : bus.c_in;
          idx_d    = '0;
          result_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        result_d = W'({slice_sum, result_q} >> SIZE);
        a_d      = a_q >> SIZE;
        b_d      = b_q >> SIZE;
        carry_d  = slice_c;
        if (idx_q == LAST_IDX) begin
          // Current slice holds the operand MSBs on the final word.
          c_out_d = slice_c;
          ovf_d   = (a_q[SIZE-1] == b_q[SIZE-1]) && (slice_sum[SIZE-1] != a_q[SIZE-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.start_ready = (state_q == S_IDLE);
  assign bus.res_valid   = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.result      = result_q;
  assign bus.c_out       = c_out_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_ks_multiword_sequencer.sv
// tb/tb_ks_multiword_sequencer.sv - directed and reference-model bench for ks_multiword_sequencer
module tb_ks_multiword_sequencer;
  localparam int SIZE  = 8;
  localparam int WORDS = 4;
  localparam int W     = SIZE * WORDS;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ks_multiword_sequencer_if #(.SIZE(SIZE), .WORDS(WORDS)) bus_if ();

  ks_multiword_sequencer #(.SIZE(SIZE), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, c_out, result} from plain W+1-bit arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic ci);
    logic [W:0] full;
    logic       ov;
    if (s) begin
      full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      ov   = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      ov   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    end
    return {ov, full};
  endfunction

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic ci);
    bus_if.op_a = a;
    bus_if.op_b = b;
    bus_if.sub  = s;
    bus_if.c_in = ci;
  endtask

  // Called at a negedge; returns at the negedge after the result edge (handshake if res_ready=1).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic ci,
                        output logic [W-1:0] r, output logic co, output logic ov, output int lat);
    int n;
    drive_op(a, b, s, ci);
    bus_if.start_valid = 1'b1;
    n = 0;
    while (!bus_if.start_ready && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (!bus_if.start_ready) chk_eq("accept_timeout", 0, 1);
    @(posedge clk); @(negedge clk);
    bus_if.start_valid = 1'b0;
    drive_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    lat = 0;
    while (!bus_if.res_valid && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    if (!bus_if.res_valid) chk_eq("res_timeout", 0, 1);
    r  = bus_if.result;
    co = bus_if.c_out;
    ov = bus_if.overflow;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] r;
    logic         co, ov;
    int           lat, n;
    logic [W+1:0] exp;
    logic [W-1:0] cur_a, cur_b;
    logic         cur_s, cur_c;

    rst = 1'b1;
    bus_if.start_valid = 1'b0;
    bus_if.res_ready   = 1'b1;
    drive_op('0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_eq("rst_start_ready", bus_if.start_ready, 1);
    chk_eq("rst_res_valid",   bus_if.res_valid,   0);
    chk_eq("rst_busy",        bus_if.busy,        0);
    chk_eq("rst_result",      bus_if.result,      0);
    chk_eq("rst_c_out",       bus_if.c_out,       0);
    chk_eq("rst_overflow",    bus_if.overflow,    0);

    // Carry out of word 0 into word 1
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, r, co, ov, lat);
    chk_eq("t1_result", r, 32'h00000100);
    chk_eq("t1_c_out", co, 0);
    chk_eq("t1_ovf", ov, 0);
    chk_eq("t1_latency_edges", lat, WORDS);

    // Carry-in ripples through every word
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, r, co, ov, lat);
    chk_eq("t2_result", r, 32'h00000000);
    chk_eq("t2_c_out", co, 1);
    chk_eq("t2_ovf", ov, 0);

    run_op(32'h00000000, 32'h00000001, 1'b1, 1'b1, r, co, ov, lat);
    chk_eq("t3a_result", r, 32'hFFFFFFFF);
    chk_eq("t3a_c_out", co, 0);
    chk_eq("t3a_ovf", ov, 0);

    run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, r, co, ov, lat);
    chk_eq("t3b_result", r, 32'h7FFFFFFF);
    chk_eq("t3b_c_out", co, 1);
    chk_eq("t3b_ovf", ov, 1);
    chk_eq("idle_hold_result", bus_if.result, 32'h7FFFFFFF);
    chk_eq("idle_hold_valid", bus_if.res_valid, 0);

    // Back-pressure in DONE with start_valid pulsing
    bus_if.res_ready = 1'b0;
    run_op(32'h00000005, 32'h00000003, 1'b0, 1'b0, r, co, ov, lat);
    chk_eq("t4_result", r, 32'h00000008);
    for (int k = 0; k < 3; k++) begin
      bus_if.start_valid = 1'b1;
      drive_op(32'h11111111, 32'h22222222, 1'b0, 1'b0);
      chk_eq("t4_hold_valid", bus_if.res_valid, 1);
      chk_eq("t4_hold_result", bus_if.result, 32'h00000008);
      chk_eq("t4_hold_c_out", bus_if.c_out, 0);
      chk_eq("t4_hold_ovf", bus_if.overflow, 0);
      chk_eq("t4_hold_start_ready", bus_if.start_ready, 0);
      @(posedge clk); @(negedge clk);
    end
    bus_if.start_valid = 1'b0;
    bus_if.res_ready   = 1'b1;
    chk_eq("t4_still_valid", bus_if.res_valid, 1);
    chk_eq("t4_still_result", bus_if.result, 32'h00000008);
    @(posedge clk); @(negedge clk);
    chk_eq("t4_release_start_ready", bus_if.start_ready, 1);
    chk_eq("t4_release_res_valid", bus_if.res_valid, 0);
    chk_eq("t4_release_result", bus_if.result, 32'h00000008);

    // Reset mid-operation at word 2
    drive_op(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b1);
    bus_if.start_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_if.start_valid = 1'b0;
    chk_eq("t5_busy", bus_if.busy, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk_eq("t5_start_ready", bus_if.start_ready, 1);
    chk_eq("t5_res_valid", bus_if.res_valid, 0);
    chk_eq("t5_busy_low", bus_if.busy, 0);
    chk_eq("t5_result", bus_if.result, 0);
    chk_eq("t5_c_out", bus_if.c_out, 0);
    repeat (WORDS + 2) begin
      @(posedge clk); @(negedge clk);
      chk_eq("t5_no_res_pulse", bus_if.res_valid, 0);
    end
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, r, co, ov, lat);
    chk_eq("t5_add_result", r, 32'h23456789);
    chk_eq("t5_add_c_out", co, 0);
    chk_eq("t5_add_ovf", ov, 0);

    // Back-to-back with start_valid held high, checked against the model
    bus_if.res_ready = 1'b1;
    cur_a = $urandom; cur_b = $urandom;
    cur_s = 1'($urandom_range(0, 1)); cur_c = 1'($urandom_range(0, 1));
    drive_op(cur_a, cur_b, cur_s, cur_c);
    bus_if.start_valid = 1'b1;
    n = 0;
    while (!bus_if.start_ready && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    chk_eq("b2b_first_ready", bus_if.start_ready, 1);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); @(negedge clk);
      exp = model(cur_a, cur_b, cur_s, cur_c);
      chk_eq("b2b_busy", bus_if.busy, 1);
      cur_a = $urandom; cur_b = $urandom;
      cur_s = 1'($urandom_range(0, 1)); cur_c = 1'($urandom_range(0, 1));
      drive_op(cur_a, cur_b, cur_s, cur_c);
      n = 0;
      while (!bus_if.res_valid && n < 20) begin
        @(posedge clk); @(negedge clk); n++;
      end
      chk_eq("b2b_valid", bus_if.res_valid, 1);
      chk_eq("b2b_result", bus_if.result, exp[W-1:0]);
      chk_eq("b2b_c_out", bus_if.c_out, exp[W]);
      chk_eq("b2b_ovf", bus_if.overflow, exp[W+1]);
      @(posedge clk); @(negedge clk);
      chk_eq("b2b_rearm", bus_if.start_ready, 1);
    end
    bus_if.start_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_eq("end_idle", bus_if.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
